// File: rtl/flb_pkg.sv
// Shared definitions for the FLB fine-code path.
// Holds the default code/row/column widths, the slewer state type and the
// code/row/column typedefs that the decoder and its bench model also use.
package flb_pkg;

    localparam int CODE_W = 8;
    localparam int COL_W  = 4;
    localparam int ROW_W  = CODE_W - COL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SLEW   = 2'd1,
        FROZEN = 2'd2
    } fsm_t;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [ROW_W-1:0]  row_t;
    typedef logic [COL_W-1:0]  col_t;

endpackage

// File: rtl/flb_code_split.sv
// Combinational split of a fine code into decoder fields.
//   code : fine code (CODE_W bits)
//   row  : code MSBs, row index for the binary-to-thermometer decoder
//   col  : code LSBs, raw (the decoder inverts them on odd rows)
//   oc   : row LSB, odd-row flag
module flb_code_split #(
    parameter int CODE_W = 8,
    parameter int COL_W  = 4
) (
    input  logic [CODE_W-1:0]       code,
    output logic [CODE_W-COL_W-1:0] row,
    output logic [COL_W-1:0]        col,
    output logic                    oc
);

    assign row = code[CODE_W-1:COL_W];
    assign oc  = code[COL_W];

    genvar gi;
    generate
        for (gi = 0; gi < COL_W; gi++) begin : g_col
            assign col[gi] = code[gi];
        end
    endgenerate

endmodule

// File: rtl/flb_code_slewer.sv
// Rate-limited fine DCO code slewer feeding the FLB row/column decoder.
// Latches targets from the loop filter and moves the applied code toward the
// target by at most STEP per tick. All outputs are registered; row/col/oc are
// split from the next code before the register so they never skew.
//   clk, rst    : clock, synchronous active-high reset
//   tgt_i       : target code, latched when tgt_vld_i is high
//   tick_i      : slew enable, at most one step per asserted cycle
//   freeze_i    : hold the applied code (targets are still latched)
//   code_o      : applied code; row_o/col_o/oc_o are its decoder fields
//   upd_o       : pulse in the cycle code_o takes a new value
//   busy_o      : slewing toward the target
//   settled_o   : code_o equals the target and not frozen
module flb_code_slewer #(
    parameter int CODE_W   = flb_pkg::CODE_W,
    parameter int COL_W    = flb_pkg::COL_W,
    parameter int STEP     = 4,
    parameter int RST_CODE = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CODE_W-1:0]       tgt_i,
    input  logic                    tgt_vld_i,
    input  logic                    tick_i,
    input  logic                    freeze_i,
    output logic [CODE_W-1:0]       code_o,
    output logic [CODE_W-COL_W-1:0] row_o,
    output logic [COL_W-1:0]        col_o,
    output logic                    oc_o,
    output logic                    upd_o,
    output logic                    busy_o,
    output logic                    settled_o
);

    import flb_pkg::*;

    localparam int ROW_W = CODE_W - COL_W;
    localparam logic [CODE_W-1:0] RST_C   = CODE_W'(RST_CODE);
    localparam logic [CODE_W-1:0] STEP_C  = CODE_W'(STEP);
    localparam logic [CODE_W:0]   STEP_W1 = (CODE_W+1)'(STEP);

    fsm_t state_reg, state_next;

    logic [CODE_W-1:0] code_reg, code_next;
    logic [CODE_W-1:0] tgt_reg, tgt_next;
    logic [CODE_W-1:0] stepped;
    logic [ROW_W-1:0]  row_reg, row_next;
    logic [COL_W-1:0]  col_reg, col_next;
    logic              oc_reg, oc_next;
    logic              upd_reg, busy_reg, settled_reg;

    logic signed [CODE_W:0] diff;
    logic signed [CODE_W:0] diff_neg;
    logic        [CODE_W:0] diff_mag;

    // One slew step toward the currently latched target. The final step
    // lands exactly on the target, so the code never leaves the code range.
    always_comb begin
        diff     = signed'({1'b0, tgt_reg}) - signed'({1'b0, code_reg});
        diff_neg = -diff;
        diff_mag = diff[CODE_W] ? unsigned'(diff_neg) : unsigned'(diff);
        if (diff_mag <= STEP_W1) begin
            stepped = tgt_reg;
        end else if (diff[CODE_W]) begin
            stepped = code_reg - STEP_C;
        end else begin
            stepped = code_reg + STEP_C;
        end
    end

    // Next-state logic. A tick steps toward the old target even when a new
    // target arrives in the same cycle; the new target only steers the state
    // decision, which re-aims (or returns to IDLE) from the resulting code.
    // Freeze wins over tick; the release cycle itself does not step.
    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        tgt_next   = tgt_vld_i ? tgt_i : tgt_reg;
        if (freeze_i) begin
            state_next = FROZEN;
        end else begin
            if (state_reg == SLEW && tick_i) begin
                code_next = stepped;
            end
            state_next = (code_next != tgt_next) ? SLEW : IDLE;
        end
    end

    flb_code_split #(
        .CODE_W (CODE_W),
        .COL_W  (COL_W)
    ) u_split (
        .code (code_next),
        .row  (row_next),
        .col  (col_next),
        .oc   (oc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            code_reg    <= RST_C;
            tgt_reg     <= RST_C;
            row_reg     <= RST_C[CODE_W-1:COL_W];
            col_reg     <= RST_C[COL_W-1:0];
            oc_reg      <= RST_C[COL_W];
            upd_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            settled_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            code_reg    <= code_next;
            tgt_reg     <= tgt_next;
            row_reg     <= row_next;
            col_reg     <= col_next;
            oc_reg      <= oc_next;
            upd_reg     <= (code_next != code_reg);
            busy_reg    <= (state_next == SLEW);
            settled_reg <= (state_next != FROZEN) && (code_next == tgt_next);
        end
    end

    assign code_o    = code_reg;
    assign row_o     = row_reg;
    assign col_o     = col_reg;
    assign oc_o      = oc_reg;
    assign upd_o     = upd_reg;
    assign busy_o    = busy_reg;
    assign settled_o = settled_reg;

endmodule

// File: tb/tb_flb_code_slewer.sv
module tb_flb_code_slewer;

    localparam int STEP = 4;

    logic       clk;
    logic       rst;
    logic [7:0] tgt_i;
    logic       tgt_vld_i;
    logic       tick_i;
    logic       freeze_i;
    logic [7:0] code_o;
    logic [3:0] row_o;
    logic [3:0] col_o;
    logic       oc_o;
    logic       upd_o;
    logic       busy_o;
    logic       settled_o;

    int checks = 0;
    int errors = 0;

    // Reference model: applied code, latched target, "frozen last cycle".
    int m_code = 128;
    int m_tgt  = 128;
    bit m_frz  = 0;
    bit m_upd  = 0;

    flb_code_slewer #(
        .CODE_W   (8),
        .COL_W    (4),
        .STEP     (STEP),
        .RST_CODE (128)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_i     (tgt_i),
        .tgt_vld_i (tgt_vld_i),
        .tick_i    (tick_i),
        .freeze_i  (freeze_i),
        .code_o    (code_o),
        .row_o     (row_o),
        .col_o     (col_o),
        .oc_o      (oc_o),
        .upd_o     (upd_o),
        .busy_o    (busy_o),
        .settled_o (settled_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic cyc(input bit r, input bit vld, input int t, input bit tk, input bit fz);
        int prev;
        int d;
        rst       = r;
        tgt_vld_i = vld;
        tgt_i     = 8'(t);
        tick_i    = tk;
        freeze_i  = fz;
        prev      = m_code;
        if (r) begin
            m_code = 128;
            m_tgt  = 128;
            m_frz  = 0;
            m_upd  = 0;
        end else begin
            if (tk && !fz && !m_frz) begin
                d = m_tgt - m_code;
                if (d <= STEP && d >= -STEP) m_code = m_tgt;
                else if (d > 0)              m_code = m_code + STEP;
                else                         m_code = m_code - STEP;
            end
            m_upd = (m_code != prev);
            if (vld) m_tgt = t;
            m_frz = fz;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        checks++;
        if (code_o !== 8'd128 || row_o !== 4'd8 || col_o !== 4'd0 || oc_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_code code=%0d row=%0d col=%0d oc=%0d required 128/8/0/0", code_o, row_o, col_o, oc_o);
        end
        checks++;
        if (upd_o !== 1'b0 || busy_o !== 1'b0 || settled_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags upd=%0b busy=%0b settled=%0b required 0/0/1", upd_o, busy_o, settled_o);
        end
        $display("test_reset done code=%0d", code_o);
    endtask

    task automatic test_slew_up;
        int exp_c[3] = '{132, 136, 137};
        int n_upd = 0;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 137, 0, 0);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL up_busy_start busy=%0b required 1", busy_o);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0);
            if (upd_o) n_upd++;
            cyc(0, 0, 0, 1, 0);
            if (upd_o) n_upd++;
            checks++;
            if (code_o !== 8'(exp_c[i])) begin
                errors++;
                $display("FAIL up_code[%0d] code=%0d required %0d", i, code_o, exp_c[i]);
            end
            $display("slew_up tick %0d code=%0d busy=%0b settled=%0b", i, code_o, busy_o, settled_o);
        end
        checks++;
        if (busy_o !== 1'b0 || settled_o !== 1'b1) begin
            errors++;
            $display("FAIL up_end busy=%0b settled=%0b required 0/1", busy_o, settled_o);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0);
            if (upd_o) n_upd++;
        end
        checks++;
        if (n_upd != 3) begin
            errors++;
            $display("FAIL up_upd_count count=%0d required 3", n_upd);
        end
    endtask

    task automatic test_slew_down;
        int exp_c[5] = '{133, 129, 125, 121, 120};
        cyc(0, 1, 120, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1, 0);
            checks++;
            if (code_o !== 8'(exp_c[i]) || row_o !== 4'(exp_c[i] / 16) ||
                col_o !== 4'(exp_c[i] % 16) || oc_o !== 1'((exp_c[i] / 16) % 2) || upd_o !== 1'b1) begin
                errors++;
                $display("FAIL down[%0d] code=%0d row=%0d col=%0d oc=%0b upd=%0b required code %0d upd 1",
                         i, code_o, row_o, col_o, oc_o, upd_o, exp_c[i]);
            end
            $display("slew_down tick %0d code=%0d row=%0d col=%0d oc=%0b", i, code_o, row_o, col_o, oc_o);
        end
    endtask

    task automatic test_row_boundary;
        int guard = 0;
        cyc(0, 1, 12, 0, 0);
        while (code_o !== 8'd12 && guard < 40) begin
            cyc(0, 0, 0, 1, 0);
            guard++;
        end
        checks++;
        if (code_o !== 8'd12) begin
            errors++;
            $display("FAIL reach_12 code=%0d required 12 (timeout)", code_o);
        end
        cyc(0, 1, 20, 0, 0);
        cyc(0, 0, 0, 1, 0);
        checks++;
        if (code_o !== 8'd16 || row_o !== 4'd1 || col_o !== 4'd0 || oc_o !== 1'b1 || upd_o !== 1'b1) begin
            errors++;
            $display("FAIL bound_16 code=%0d row=%0d col=%0d oc=%0b upd=%0b required 16/1/0/1/1",
                     code_o, row_o, col_o, oc_o, upd_o);
        end
        cyc(0, 0, 0, 1, 0);
        checks++;
        if (code_o !== 8'd20) begin
            errors++;
            $display("FAIL bound_20 code=%0d required 20", code_o);
        end
        $display("row_boundary code=%0d row=%0d col=%0d", code_o, row_o, col_o);
    endtask

    task automatic test_freeze;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 200, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
        checks++;
        if (code_o !== 8'd140) begin
            errors++;
            $display("FAIL frz_pre code=%0d required 140", code_o);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1, 1);
            checks++;
            if (code_o !== 8'd140 || upd_o !== 1'b0 || settled_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL frz_hold[%0d] code=%0d upd=%0b settled=%0b busy=%0b required 140/0/0/0",
                         i, code_o, upd_o, settled_o, busy_o);
            end
        end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        checks++;
        if (code_o !== 8'd144 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL frz_resume code=%0d busy=%0b required 144/1", code_o, busy_o);
        end
        $display("freeze resume code=%0d", code_o);
    endtask

    task automatic test_retarget;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 200, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 100, 1, 0);
        checks++;
        if (code_o !== 8'd144) begin
            errors++;
            $display("FAIL retgt_old code=%0d required 144", code_o);
        end
        cyc(0, 0, 0, 1, 0);
        checks++;
        if (code_o !== 8'd140 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL retgt_rev code=%0d busy=%0b required 140/1", code_o, busy_o);
        end
        $display("retarget code=%0d", code_o);
    endtask

    task automatic test_reset_mid_slew;
        bit any_upd = 0;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 200, 0, 0);
        for (int i = 0; i < 11; i++) cyc(0, 0, 0, 1, 0);
        checks++;
        if (code_o !== 8'd172) begin
            errors++;
            $display("FAIL rms_pre code=%0d required 172", code_o);
        end
        cyc(1, 0, 0, 1, 0);
        checks++;
        if (code_o !== 8'd128 || busy_o !== 1'b0 || settled_o !== 1'b1 || row_o !== 4'd8 || upd_o !== 1'b0) begin
            errors++;
            $display("FAIL rms_reset code=%0d busy=%0b settled=%0b row=%0d upd=%0b required 128/0/1/8/0",
                     code_o, busy_o, settled_o, row_o, upd_o);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0);
            if (upd_o) any_upd = 1;
        end
        checks++;
        if (code_o !== 8'd128 || any_upd) begin
            errors++;
            $display("FAIL rms_after code=%0d upd_seen=%0b required 128/0", code_o, any_upd);
        end
        $display("reset_mid_slew code=%0d", code_o);
    endtask

    task automatic test_random;
        int t, sel;
        bit r, vld, tk, fz;
        int bad = 0;
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 63) == 0);
            vld = ($urandom_range(0, 5) == 0);
            tk  = ($urandom_range(0, 1) == 1);
            fz  = ($urandom_range(0, 11) == 0);
            sel = $urandom_range(0, 7);
            if (sel == 0)      t = 0;
            else if (sel == 1) t = 255;
            else if (sel == 2) t = m_code;
            else               t = $urandom_range(0, 255);
            cyc(r, vld, t, tk, fz);
            checks++;
            if (code_o !== 8'(m_code) || row_o !== 4'(m_code / 16) || col_o !== 4'(m_code % 16) ||
                oc_o !== 1'((m_code / 16) % 2) || upd_o !== m_upd ||
                busy_o !== (!m_frz && m_code != m_tgt) || settled_o !== (!m_frz && m_code == m_tgt)) begin
                errors++;
                bad++;
                $display("FAIL rand[%0d] code=%0d row=%0d col=%0d oc=%0b upd=%0b busy=%0b settled=%0b required code %0d tgt %0d frz %0b upd %0b",
                         n, code_o, row_o, col_o, oc_o, upd_o, busy_o, settled_o, m_code, m_tgt, m_frz, m_upd);
            end
        end
        $display("test_random 600 cycles, %0d bad", bad);
    endtask

    initial begin
        rst       = 1'b1;
        tgt_i     = 8'd0;
        tgt_vld_i = 1'b0;
        tick_i    = 1'b0;
        freeze_i  = 1'b0;
        test_reset;
        test_slew_up;
        test_slew_down;
        test_row_boundary;
        test_freeze;
        test_retarget;
        test_reset_mid_slew;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
